// File: rtl/shift_pkg.sv
// Shared types for the pipelined shifter: operation modes, direction
// encoding and the per-stage control payload carried down the pipeline.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_ROT  = 2'b00,
    SH_LSL  = 2'b01,
    SH_ASR  = 2'b10,
    SH_RSVD = 2'b11
  } shmode_e;

  // Logical shift uses one encoding for both directions.
  localparam shmode_e SH_LSR = SH_LSL;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Data, shamt and tag widths are parameter-dependent, so they travel as
  // separate buses alongside this fixed-width control part of the payload.
  typedef struct packed {
    shmode_e mode;
    logic    dir;
    logic    sign;
  } ctl_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: conditionally moves the operand by STEP bits
// (rotate, zero fill or sign fill) and registers it with valid/ready.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     up_valid,
  output logic                     up_ready,
  input  logic [WIDTH-1:0]         up_data,
  input  logic [$clog2(WIDTH)-1:0] up_shamt,
  input  ctl_t                     up_ctl,
  input  logic [TAG_W-1:0]         up_tag,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [WIDTH-1:0]         dn_data,
  output logic [$clog2(WIDTH)-1:0] dn_shamt,
  output ctl_t                     dn_ctl,
  output logic [TAG_W-1:0]         dn_tag,
  output logic                     dn_zero
);

  localparam int unsigned BIT = $clog2(STEP);

  logic             is_rot;
  logic             fill_bit;
  logic [STEP-1:0]  fill;
  logic [WIDTH-1:0] moved;

  always_comb begin
    is_rot   = (up_ctl.mode == SH_ROT) || (up_ctl.mode == SH_RSVD);
    // Arithmetic right fills from the operand's original sign, not this stage's MSB.
    fill_bit = (up_ctl.mode == SH_ASR) && (up_ctl.dir == DIR_RIGHT) && up_ctl.sign;
    fill     = {STEP{fill_bit}};
    if (is_rot) begin
      fill = (up_ctl.dir == DIR_RIGHT) ? up_data[STEP-1:0] : up_data[WIDTH-1 -: STEP];
    end
    moved = up_data;
    if (up_shamt[BIT]) begin
      if (up_ctl.dir == DIR_RIGHT) moved = {fill, up_data[WIDTH-1:STEP]};
      else                         moved = {up_data[WIDTH-STEP-1:0], fill};
    end
  end

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_shamt <= '0;
      dn_ctl   <= '0;
      dn_tag   <= '0;
      dn_zero  <= 1'b0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data  <= moved;
        dn_shamt <= up_shamt;
        dn_ctl   <= up_ctl;
        dn_tag   <= up_tag;
        dn_zero  <= (moved == '0);
      end
    end
  end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined rotate/shift unit: one registered stage per shift-amount bit,
// full valid/ready backpressure, tag and zero flag carried with each result.
module pipelined_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  input  logic                     in_dir,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               valid_s [SHAMT_W+1];
  logic               ready_s [SHAMT_W+1];
  logic [WIDTH-1:0]   data_s  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
  ctl_t               ctl_s   [SHAMT_W+1];
  logic [TAG_W-1:0]   tag_s   [SHAMT_W+1];
  logic [SHAMT_W:1]   zero_s;
  logic               unused_tail;

  assign valid_s[0]      = in_valid;
  assign data_s[0]       = in_data;
  assign shamt_s[0]      = in_shamt;
  assign ctl_s[0].mode   = shmode_e'(in_mode);
  assign ctl_s[0].dir    = in_dir;
  assign ctl_s[0].sign   = in_data[WIDTH-1];
  assign tag_s[0]        = in_tag;
  assign in_ready        = ready_s[0];
  assign ready_s[SHAMT_W] = out_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .STEP  (2 ** k),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .up_valid (valid_s[k]),
      .up_ready (ready_s[k]),
      .up_data  (data_s[k]),
      .up_shamt (shamt_s[k]),
      .up_ctl   (ctl_s[k]),
      .up_tag   (tag_s[k]),
      .dn_valid (valid_s[k+1]),
      .dn_ready (ready_s[k+1]),
      .dn_data  (data_s[k+1]),
      .dn_shamt (shamt_s[k+1]),
      .dn_ctl   (ctl_s[k+1]),
      .dn_tag   (tag_s[k+1]),
      .dn_zero  (zero_s[k+1])
    );
  end

  assign out_valid = valid_s[SHAMT_W];
  assign out_data  = data_s[SHAMT_W];
  assign out_tag   = tag_s[SHAMT_W];
  assign out_zero  = zero_s[SHAMT_W];

  // Only the last stage's zero flag is meaningful; leftover sideband ends here.
  assign unused_tail = ^{shamt_s[SHAMT_W], ctl_s[SHAMT_W], zero_s[SHAMT_W-1:1]};

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit (WIDTH=32): directed cases,
// backpressure, random stream against an arithmetic reference, async reset.
module tb_pipelined_shift_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned SW  = 5;
  localparam int unsigned TW  = 4;
  localparam int unsigned LAT = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic          in_dir;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  pipelined_shift_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic          zero;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           errors  = 0;
  int           cyc     = 0;
  bit           took;
  bit           lat_chk;
  logic [W-1:0] cur_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference computed directly from the operation definitions.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s,
                                         input logic dir, input logic [1:0] mode);
    logic [2*W-1:0] dd;
    logic [2*W-1:0] t;
    dd = {d, d};
    case (mode)
      2'b01:   return dir ? (d >> s) : (d << s);
      2'b10:   return dir ? W'($signed(d) >>> s) : (d << s);
      default: begin
        if (dir) begin
          t = dd >> s;
          return t[W-1:0];
        end else begin
          t = dd << s;
          return t[2*W-1:W];
        end
      end
    endcase
  endfunction

  // One clock: observe outputs and handshakes before the edge, then advance.
  task automatic step();
    exp_t e;
    #1;
    took = 1'b0;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check("data", out_data, q[0].data);
        check("zero", 32'(out_zero), 32'(q[0].zero));
        check("tag", 32'(out_tag), 32'(q[0].tag));
        if (out_ready) begin
          if (q[0].lat) check("latency", 32'(cyc - q[0].acc), 32'(LAT));
          void'(q.pop_front());
        end
      end
    end
    if (in_valid && in_ready) begin
      e.data = cur_exp;
      e.zero = (cur_exp == '0);
      e.tag  = in_tag;
      e.acc  = cyc;
      e.lat  = lat_chk;
      q.push_back(e);
      took = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] d, input int s, input logic dir,
                      input logic [1:0] mode, input logic [TW-1:0] tag,
                      input logic [W-1:0] exp);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SW'(s);
    in_dir   = dir;
    in_mode  = mode;
    in_tag   = tag;
    cur_exp  = exp;
    for (int i = 0; i < 50; i++) begin
      step();
      if (took) break;
    end
    if (!took) check("send_timeout", 32'(took), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    check("drain_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int idx;
    int n;
    logic [W-1:0] bp_d [8];

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_dir    = 1'b0;
    in_mode   = 2'b00;
    in_tag    = '0;
    out_ready = 1'b1;
    lat_chk   = 1'b0;
    cur_exp   = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed cases with spec-derived results, unstalled latency checked.
    lat_chk = 1'b1;
    send(32'h80000001, 1,  1'b1, 2'b00, 4'h1, 32'hC0000000);
    send(32'h12345678, 8,  1'b0, 2'b00, 4'h2, 32'h34567812);
    send(32'h80000000, 31, 1'b1, 2'b10, 4'h3, 32'hFFFFFFFF);
    send(32'h80000000, 31, 1'b1, 2'b01, 4'h4, 32'h00000001);
    send(32'hFFFFFFFF, 31, 1'b0, 2'b01, 4'h5, 32'h80000000);
    send(32'h0000000F, 4,  1'b0, 2'b11, 4'h6, 32'h000000F0);
    send(32'h00000001, 0,  1'b0, 2'b01, 4'h7, 32'h00000001);
    send(32'h00000001, 1,  1'b1, 2'b01, 4'h8, 32'h00000000);
    send(32'hF00000F0, 4,  1'b0, 2'b10, 4'h9, 32'h00000F00);
    send(32'h40000000, 3,  1'b1, 2'b10, 4'hA, 32'h08000000);
    drain();
    lat_chk = 1'b0;

    // Backpressure: 8 items against a stalled output.
    for (int i = 0; i < 8; i++) bp_d[i] = $urandom;
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      if (idx < 8) begin
        in_valid = 1'b1;
        in_data  = bp_d[idx];
        in_shamt = SW'(idx * 3);
        in_dir   = idx[0];
        in_mode  = 2'(idx);
        in_tag   = TW'(idx);
        cur_exp  = model(bp_d[idx], idx * 3, idx[0], 2'(idx));
      end
      step();
      if (took) idx++;
    end
    check("bp_accepted", 32'(idx), 32'd5);
    #1 check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && idx < 8; i++) begin
      in_valid = 1'b1;
      in_data  = bp_d[idx];
      in_shamt = SW'(idx * 3);
      in_dir   = idx[0];
      in_mode  = 2'(idx);
      in_tag   = TW'(idx);
      cur_exp  = model(bp_d[idx], idx * 3, idx[0], 2'(idx));
      step();
      if (took) idx++;
    end
    check("bp_all_sent", 32'(idx), 32'd8);
    drain();

    // Random stream with random output backpressure.
    n = 0;
    in_valid = 1'b1;
    in_data  = $urandom;
    in_shamt = SW'($urandom_range(0, W - 1));
    in_dir   = 1'($urandom_range(0, 1));
    in_mode  = 2'($urandom_range(0, 3));
    in_tag   = '0;
    for (int i = 0; i < 2000 && n < 100; i++) begin
      cur_exp   = model(in_data, int'(in_shamt), in_dir, in_mode);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (took) begin
        n++;
        in_data  = $urandom;
        in_shamt = SW'($urandom_range(0, W - 1));
        in_dir   = 1'($urandom_range(0, 1));
        in_mode  = 2'($urandom_range(0, 3));
        in_tag   = TW'(n);
      end
    end
    check("rand_accepted", 32'(n), 32'd100);
    drain();

    // Asynchronous reset with three items in flight.
    out_ready = 1'b0;
    send(32'hAAAA5555, 1, 1'b0, 2'b00, 4'hB, 32'h5554AAAB);
    send(32'h0000FFFF, 4, 1'b1, 2'b01, 4'hC, 32'h00000FFF);
    send(32'h12345678, 2, 1'b0, 2'b01, 4'hD, 32'h48D159E0);
    for (int i = 0; i < 10 && !out_valid; i++) step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    lat_chk = 1'b1;
    send(32'h00000003, 31, 1'b1, 2'b00, 4'hE, 32'h00000006);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_shift_unit.md
Name: pipelined_shift_unit

Overview:
Parametrised, pipelined successor to the team's 32-bit combinational rotator. It supports rotate, logical shift and arithmetic shift in both directions over a configurable data width. There is one registered stage per shift-amount bit, with a valid/ready handshake and full backpressure, so it can sit between streaming datapath blocks at one result per clock. Status flags and an opaque tag travel with each operand.

Parameters:
WIDTH, 32, data width in bits; power of 2, >= 4.
SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
TAG_W, 4, width of the sideband tag carried unchanged to the output.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand presented.
in_ready  out  1  block can accept the operand this cycle.
in_data  in  WIDTH  operand.
in_shamt  in  SHAMT_W  shift/rotate amount, 0..WIDTH-1.
in_dir  in  1  1 = right, 0 = left.
in_mode  in  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved (executes as rotate).
in_tag  in  TAG_W  sideband, passed through.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts the result.
out_data  out  WIDTH  result.
out_zero  out  1  out_data == 0.
out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (async assert, sync-safe deassert by the top level): all stage valid bits cleared. out_valid=0, out_data=0, out_zero=0, out_tag=0. in_ready=1 in the first cycle after reset.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Pipeline structure: SHAMT_W registered stages. Stage k applies a 2^k move when shamt bit k is set. Stage k carries data, remaining shamt bits, dir, mode, the original sign bit (in_data[WIDTH-1]) and tag.
- Latency: exactly SHAMT_W cycles from input transfer to out_valid when unstalled (5 for WIDTH=32). Throughput is 1 per cycle.
- Stage advance: stage k loads when ready_k = !valid_k || ready_{k+1}; ready_{SHAMT_W} = out_ready. in_ready = ready_0 (combinational through the chain; no bubble insertion).
- Stall: while out_valid && !out_ready, every full stage holds its contents, and out_data/out_tag remain stable. Empty stages still fill, so up to SHAMT_W items are buffered before in_ready drops.
- Rotate: bits leaving one end enter the other.
- Logical shift: vacated positions are 0.
- Arithmetic shift, right: vacated positions take the original sign bit, not the current stage's MSB.
- Arithmetic shift, left: identical to logical left.
- Mode 11: behaves exactly as mode 00.
- shamt=0: out_data = in_data for every mode and direction.
- out_zero is registered in the final stage alongside out_data, never derived from the combinational output.
- Ordering: results leave strictly in acceptance order; no reordering and no drops.
- Simultaneous input and output transfer on a full pipeline: permitted. Occupancy stays unchanged.
- Reset mid-operation: all in-flight items are discarded with no output. After reset release the first accepted item behaves as from idle.
- X-safety: data/tag registers update only when their stage loads. Valid bits are the only reset-critical state, but all registers are reset for deterministic simulation.

Decomposition:
- Package shift_pkg:
  - mode enum SH_ROT=2'b00, SH_LSL/LSR=2'b01, SH_ASR=2'b10, SH_RSVD=2'b11
  - DIR_LEFT=0, DIR_RIGHT=1
  - stage payload struct: data, shamt, dir, mode, sign, tag
- Sub-module shift_stage (parameter WIDTH, STEP): one stage that moves by STEP with rotate, zero or sign fill plus its pipeline register and handshake. Instantiated SHAMT_W times via generate with STEP=2^k.

Test Plan (WIDTH=32):
- Rotate right 0x80000001 by 1, then rotate left 0x12345678 by 8 -> out_data 0xC0000000 then 0x34567812, each 5 cycles after its acceptance, tags preserved.
- Arithmetic right 0x80000000 by 31 -> 0xFFFFFFFF. Logical right of the same by 31 -> 0x00000001. Logical left 0xFFFFFFFF by 31 -> 0x80000000. Mode 11 left 0x0000000F by 4 -> 0x000000F0.
- Logical left 0x00000001 by 0 -> 0x00000001 with out_zero=0. Logical right 0x00000001 by 1 -> 0x00000000 with out_zero=1.
- Backpressure: 8 back-to-back inputs with out_ready=0 for 12 cycles -> in_ready drops after exactly 5 accepted, out_data stable while stalled, all 8 delivered in order once out_ready=1.
- Full-throughput stream of 100 random ops against a reference model with random out_ready toggling -> zero mismatches, no lost or duplicated tags.
- reset_n pulsed low with 3 items in flight -> out_valid=0 immediately (asynchronous), none of the 3 ever appear, and the next input emerges after 5 cycles.
